// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read feeding a 2-entry {pc, bundle} FIFO toward decode.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pc_in,
    input  logic         squash_in,
    input  logic         halt_in,
    output logic         stall_out,
    output logic         imem_rd_en,
    output logic [31:0]  imem_addr,
    input  logic [127:0] imem_rdata,
    output logic         dec_valid,
    input  logic         dec_ready,
    output logic [31:0]  dec_pc,
    output logic [127:0] dec_bundle,
    output logic         fetch_halted,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_squashed
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

    state_t         state, state_next;
    logic [31:0]    pc_mem     [2];
    logic [127:0]   bundle_mem [2];
    logic           wr_ptr, rd_ptr;
    logic [1:0]     count;
    logic           req_v;
    logic [31:0]    req_pc;
    logic           push, pop;
    logic [2:0]     occupancy;

    // Occupancy counts the in-flight response as a slot it will need next cycle.
    assign occupancy  = {1'b0, count} + {2'b00, req_v} - {2'b00, pop};
    assign stall_out  = rst || (occupancy >= 3'd2) || (state != RUN);
    assign imem_rd_en = !rst && (state == RUN) && !halt_in && ((occupancy < 3'd2) || squash_in);
    assign imem_addr  = pc_in;

    assign dec_valid  = !rst && (count != 2'd0) && !squash_in;
    assign pop        = dec_valid && dec_ready;
    assign push       = req_v && !squash_in;
    assign dec_pc     = pc_mem[rd_ptr];
    assign dec_bundle = bundle_mem[rd_ptr];

    assign fetch_halted = (state == HALTED);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = RUN;
            RUN:     if (halt_in) state_next = DRAIN;
            DRAIN:   if (squash_in || (count == 2'd0 && !req_v)) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            req_v  <= 1'b0;
            req_pc <= 32'd0;
            // NOTE: the storage is small and decode sees it directly, so it is reset explicitly.
            for (int i = 0; i < 2; i++) begin
                pc_mem[i]     <= 32'd0;
                bundle_mem[i] <= 128'd0;
            end
        end else begin
            state  <= state_next;
            req_v  <= imem_rd_en;
            req_pc <= pc_in;
            if (squash_in) begin
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]     <= req_pc;
                    bundle_mem[wr_ptr] <= imem_rdata;
                    wr_ptr             <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, squashed_q;
    logic [1:0]  dropped;
    logic [32:0] squashed_sum;

    // A squash discards every buffered bundle plus the response arriving this cycle.
    assign dropped      = count + {1'b0, req_v};
    assign squashed_sum = {1'b0, squashed_q} + {31'd0, dropped};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q  <= 32'd0;
            squashed_q <= 32'd0;
        end else begin
            if (pop && fetched_q != 32'hFFFF_FFFF)
                fetched_q <= fetched_q + 32'd1;
            if (squash_in)
                squashed_q <= squashed_sum[32] ? 32'hFFFF_FFFF : squashed_sum[31:0];
        end
    end

    assign perf_fetched  = fetched_q;
    assign perf_squashed = squashed_q;
`else
    assign perf_fetched  = 32'd0;
    assign perf_squashed = 32'd0;
`endif

endmodule
